// File: rtl/dice_game_pkg.sv
// Shared colour encodings, game state enum and colour-to-steps mapping.
package dice_game_pkg;

  localparam logic [1:0] COLOR_NONE  = 2'b00;
  localparam logic [1:0] COLOR_RED   = 2'b01;
  localparam logic [1:0] COLOR_GREEN = 2'b10;
  localparam logic [1:0] COLOR_BLUE  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_ROLL  = 3'd1,
    S_MOVE       = 3'd2,
    S_WAIT_CLEAR = 3'd3,
    S_NEXT       = 3'd4,
    S_OVER       = 3'd5
  } game_state_e;

  // Step counts come from the instantiating block's parameters.
  function automatic logic [1:0] color_to_steps(input logic [1:0] color,
                                                input logic [1:0] s_red,
                                                input logic [1:0] s_green,
                                                input logic [1:0] s_blue);
    logic [1:0] steps;
    case (color)
      COLOR_RED:   steps = s_red;
      COLOR_GREEN: steps = s_green;
      COLOR_BLUE:  steps = s_blue;
      default:     steps = 2'd0;
    endcase
    return steps;
  endfunction

endpackage

// File: rtl/dice_race_game_fsm_step_timer.sv
// Animation tick counter: counts 0..STEP_TICKS-1 while enabled, pulses tc
// on the terminal count and wraps to zero.
module step_timer #(
  parameter int STEP_TICKS = 25_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int CNT_W = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_TICKS - 1);

  logic [CNT_W-1:0] cnt;

  assign tc = enable && (cnt == LAST);

  // Counter: clear wins, wrap on terminal count, hold when disabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)              cnt <= '0;
    else if (clear || tc)   cnt <= '0;
    else if (enable)        cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/dice_race_game_fsm.sv
// Board race controller: takes dice colours, animates token moves one square
// per STEP_TICKS, rotates turns and flags the winner. All outputs registered.
module dice_race_game_fsm
  import dice_game_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int BOARD_LEN   = 20,
  parameter int STEP_TICKS  = 25_000_000,
  parameter int STEPS_RED   = 1,
  parameter int STEPS_GREEN = 2,
  parameter int STEPS_BLUE  = 3,
  localparam int POS_W      = $clog2(BOARD_LEN + 1)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start_pulse,
  input  logic [1:0]                   stable_color,
  input  logic                         result_ready,
  input  logic                         turn_end,
  output logic [2:0]                   game_state,
  output logic [1:0]                   current_player,
  output logic [NUM_PLAYERS*POS_W-1:0] positions,
  output logic [1:0]                   last_roll,
  output logic                         step_pulse,
  output logic [1:0]                   winner,
  output logic                         game_over
);

  localparam logic [POS_W+1:0] FINISH_EXT  = (POS_W+2)'(BOARD_LEN);
  localparam logic [POS_W-1:0] FINISH      = POS_W'(BOARD_LEN);
  localparam logic [1:0]       LAST_PLAYER = 2'(NUM_PLAYERS - 1);

  game_state_e                           state_q, state_d;
  logic [NUM_PLAYERS-1:0][POS_W-1:0]     pos_q, pos_d;
  logic [1:0]                            cp_q, cp_d;
  logic [1:0]                            rem_q, rem_d;
  logic [1:0]                            last_q, last_d;
  logic                                  step_q, step_d;
  logic [1:0]                            win_q, win_d;
  logic                                  over_q, over_d;
  logic                                  clr_q, clr_d;

  logic             timer_clear, timer_tc;
  logic [POS_W-1:0] cur_pos, step_pos;
  logic [POS_W+1:0] new_pos;

  step_timer #(.STEP_TICKS(STEP_TICKS)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (timer_clear),
    .enable (state_q == S_MOVE),
    .tc     (timer_tc)
  );

  // Current player's square and its saturated one-step successor.
  always_comb begin
    cur_pos = '0;
    for (int p = 0; p < NUM_PLAYERS; p++)
      if (cp_q == 2'(p)) cur_pos = pos_q[p];
    new_pos  = {2'b00, cur_pos} + 1'b1;
    step_pos = (new_pos >= FINISH_EXT) ? FINISH : new_pos[POS_W-1:0];
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    cp_d        = cp_q;
    rem_d       = rem_q;
    last_d      = last_q;
    step_d      = 1'b0;
    win_d       = win_q;
    over_d      = over_q;
    clr_d       = clr_q;
    timer_clear = 1'b0;
    case (state_q)
      S_IDLE: if (start_pulse) begin
        pos_d   = '0;
        cp_d    = 2'd0;
        state_d = S_WAIT_ROLL;
      end
      S_WAIT_ROLL: if (result_ready && stable_color != COLOR_NONE) begin
        rem_d       = color_to_steps(stable_color, 2'(STEPS_RED),
                                     2'(STEPS_GREEN), 2'(STEPS_BLUE));
        last_d      = rem_d;
        clr_d       = 1'b0;
        timer_clear = 1'b1;
        state_d     = S_MOVE;
      end
      S_MOVE: begin
        if (turn_end) clr_d = 1'b1;
        if (timer_tc) begin
          for (int p = 0; p < NUM_PLAYERS; p++)
            if (cp_q == 2'(p)) pos_d[p] = step_pos;
          step_d = 1'b1;
          rem_d  = rem_q - 1'b1;
          if (step_pos == FINISH) begin
            rem_d   = 2'd0;
            win_d   = cp_q;
            over_d  = 1'b1;
            state_d = S_OVER;
          end else if (rem_q <= 2'd1) begin
            rem_d   = 2'd0;
            state_d = (clr_q || turn_end) ? S_NEXT : S_WAIT_CLEAR;
          end
        end
      end
      S_WAIT_CLEAR: if (turn_end) state_d = S_NEXT;
      S_NEXT: begin
        cp_d    = (cp_q == LAST_PLAYER) ? 2'd0 : cp_q + 1'b1;
        last_d  = 2'd0;
        state_d = S_WAIT_ROLL;
      end
      S_OVER: if (start_pulse) begin
        pos_d   = '0;
        cp_d    = 2'd0;
        win_d   = 2'd0;
        over_d  = 1'b0;
        last_d  = 2'd0;
        state_d = S_WAIT_ROLL;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pos_q   <= '0;
      cp_q    <= 2'd0;
      rem_q   <= 2'd0;
      last_q  <= 2'd0;
      step_q  <= 1'b0;
      win_q   <= 2'd0;
      over_q  <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      cp_q    <= cp_d;
      rem_q   <= rem_d;
      last_q  <= last_d;
      step_q  <= step_d;
      win_q   <= win_d;
      over_q  <= over_d;
      clr_q   <= clr_d;
    end
  end

  assign game_state     = state_q;
  assign current_player = cp_q;
  assign positions      = pos_q;
  assign last_roll      = last_q;
  assign step_pulse     = step_q;
  assign winner         = win_q;
  assign game_over      = over_q;

endmodule
